// File: rtl/uart_line_buffer_if.sv
// Receiver/transmitter handshake bundle for uart_line_buffer.
//   i_rx_strobe : receiver byte-valid level (byte taken on its rising edge)
//   i_rx_data   : received byte, valid while i_rx_strobe is high
//   i_tx_busy   : transmitter busy
//   o_tx_start  : one-cycle start pulse to the transmitter
//   o_tx_data   : byte to transmit, held from the start pulse until busy falls
// master = line buffer side, slave = receiver/transmitter side.
interface uart_line_buffer_if;
  logic       i_rx_strobe;
  logic [7:0] i_rx_data;
  logic       i_tx_busy;
  logic       o_tx_start;
  logic [7:0] o_tx_data;

  modport master (
    input  i_rx_strobe,
    input  i_rx_data,
    input  i_tx_busy,
    output o_tx_start,
    output o_tx_data
  );

  modport slave (
    output i_rx_strobe,
    output i_rx_data,
    output i_tx_busy,
    input  o_tx_start,
    input  o_tx_data
  );
endinterface

// File: rtl/uart_line_buffer.sv
// Line buffer between a UART receiver and transmitter. Received bytes are
// stored until TERMINATOR arrives, then the line is replayed to the
// transmitter in arrival order or reversed, one byte per handshake.
// Ports:
//   i_Clk, i_Rst_n : clock, asynchronous active-low reset
//   bus            : receiver/transmitter handshake (uart_line_buffer_if.master)
//   o_count        : bytes currently stored (0..DEPTH)
//   o_sending      : high while a line is being replayed
//   o_overflow     : sticky until line end, a byte was lost to a full buffer
//   o_dropped      : sticky until reset, a byte arrived during replay
module uart_line_buffer #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = $clog2(DEPTH),
  parameter logic [7:0]  TERMINATOR  = 8'h01,
  parameter bit          REVERSE     = 1'b1,
  parameter bit          APPEND_TERM = 1'b0
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  uart_line_buffer_if.master    bus,
  output logic [ADDR_W:0]       o_count,
  output logic                  o_sending,
  output logic                  o_overflow,
  output logic                  o_dropped
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_RX, S_LOAD, S_START, S_GAP, S_WAIT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               strobe_q;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               term_sent_q, term_sent_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [CNT_W-1:0]   count_d;
  logic               sending_d, overflow_d, dropped_d;
  logic               rx_take;
  logic               ram_we;

  logic [7:0] ram [DEPTH];

  // Only the rising edge of the receiver strobe counts as a new byte.
  assign rx_take = bus.i_rx_strobe & ~strobe_q;

  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;

  // Line storage; contents are not reset.
  always_ff @(posedge i_Clk) begin
    if (ram_we) ram[ADDR_W'(o_count)] <= bus.i_rx_data;
  end

  // State and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= S_RX;
      strobe_q    <= 1'b0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      term_sent_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      o_count     <= '0;
      o_sending   <= 1'b0;
      o_overflow  <= 1'b0;
      o_dropped   <= 1'b0;
    end else begin
      state_q     <= state_d;
      strobe_q    <= bus.i_rx_strobe;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      term_sent_q <= term_sent_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      o_count     <= count_d;
      o_sending   <= sending_d;
      o_overflow  <= overflow_d;
      o_dropped   <= dropped_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    term_sent_d = term_sent_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    count_d     = o_count;
    sending_d   = o_sending;
    overflow_d  = o_overflow;
    dropped_d   = o_dropped;
    ram_we      = 1'b0;

    case (state_q)
      S_RX: begin
        if (rx_take) begin
          if (bus.i_rx_data != TERMINATOR) begin
            if (o_count < CNT_W'(DEPTH)) begin
              ram_we  = 1'b1;
              count_d = o_count + CNT_W'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end else if ((o_count != '0) || APPEND_TERM) begin
            state_d     = S_LOAD;
            sending_d   = 1'b1;
            rd_ptr_d    = REVERSE ? ADDR_W'(o_count - CNT_W'(1)) : '0;
            remaining_d = o_count;
            term_sent_d = 1'b0;
          end
        end
      end
      S_LOAD: begin
        if (remaining_q != '0) begin
          tx_data_d = ram[rd_ptr_q];
          state_d   = S_START;
        end else if (APPEND_TERM && !term_sent_q) begin
          tx_data_d   = TERMINATOR;
          term_sent_d = 1'b1;
          state_d     = S_START;
        end else begin
          state_d = S_DONE;
        end
      end
      S_START: begin
        if (!bus.i_tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = S_GAP;
        end
      end
      // Gives the transmitter one cycle to raise busy after the start pulse.
      S_GAP: state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.i_tx_busy) begin
          if (term_sent_q) begin
            state_d = S_DONE;
          end else begin
            remaining_d = remaining_q - CNT_W'(1);
            rd_ptr_d    = REVERSE ? rd_ptr_q - ADDR_W'(1) : rd_ptr_q + ADDR_W'(1);
            state_d     = S_LOAD;
          end
        end
      end
      S_DONE: begin
        count_d    = '0;
        overflow_d = 1'b0;
        sending_d  = 1'b0;
        state_d    = S_RX;
      end
      default: state_d = S_RX;
    endcase

    // Bytes arriving outside S_RX (including S_DONE) are never stored.
    if (rx_take && (state_q != S_RX)) dropped_d = 1'b1;
  end

endmodule

// File: tb/tb_uart_line_buffer.sv
module tb_uart_line_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_line_buffer_if if_a ();
  uart_line_buffer_if if_b ();
  uart_line_buffer_if if_c ();

  logic [8:0] count_a;
  logic [4:0] count_b;
  logic [2:0] count_c;
  logic [2:0] sending_w, overflow_w, dropped_w;

  // A: reverse echo, 256 deep. B: forward with appended terminator. C: 4 deep.
  uart_line_buffer #(.DEPTH(256), .TERMINATOR(8'h01), .REVERSE(1'b1), .APPEND_TERM(1'b0)) u_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(if_a.master), .o_count(count_a),
    .o_sending(sending_w[0]), .o_overflow(overflow_w[0]), .o_dropped(dropped_w[0]));
  uart_line_buffer #(.DEPTH(16), .TERMINATOR(8'h01), .REVERSE(1'b0), .APPEND_TERM(1'b1)) u_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(if_b.master), .o_count(count_b),
    .o_sending(sending_w[1]), .o_overflow(overflow_w[1]), .o_dropped(dropped_w[1]));
  uart_line_buffer #(.DEPTH(4), .TERMINATOR(8'h01), .REVERSE(1'b1), .APPEND_TERM(1'b0)) u_c (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(if_c.master), .o_count(count_c),
    .o_sending(sending_w[2]), .o_overflow(overflow_w[2]), .o_dropped(dropped_w[2]));

  int n_tests = 0;
  int n_fail  = 0;
  int starts_a = 0, starts_b = 0, starts_c = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_c[$];

  // Transmitter models: busy for 6 cycles after sampling a start pulse.
  int bcnt_a = 0, bcnt_b = 0, bcnt_c = 0;
  always @(posedge clk) begin
    if (if_a.o_tx_start) bcnt_a <= 6; else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
    if (if_b.o_tx_start) bcnt_b <= 6; else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
    if (if_c.o_tx_start) bcnt_c <= 6; else if (bcnt_c != 0) bcnt_c <= bcnt_c - 1;
  end
  assign if_a.i_tx_busy = (bcnt_a != 0);
  assign if_b.i_tx_busy = (bcnt_b != 0);
  assign if_c.i_tx_busy = (bcnt_c != 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every start pulse must match the next expected byte.
  always @(negedge clk) begin
    if (rst_n && if_a.o_tx_start) begin
      starts_a++;
      chk("a_tx_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) chk("a_tx_data", 32'(if_a.o_tx_data), 32'(exp_a.pop_front()));
    end
    if (rst_n && if_b.o_tx_start) begin
      starts_b++;
      chk("b_tx_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) chk("b_tx_data", 32'(if_b.o_tx_data), 32'(exp_b.pop_front()));
    end
    if (rst_n && if_c.o_tx_start) begin
      starts_c++;
      chk("c_tx_expected", 32'(exp_c.size() != 0), 32'd1);
      if (exp_c.size() != 0) chk("c_tx_data", 32'(if_c.o_tx_data), 32'(exp_c.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic s, input logic [7:0] d);
    case (k)
      0: begin if_a.i_rx_strobe = s; if_a.i_rx_data = d; end
      1: begin if_b.i_rx_strobe = s; if_b.i_rx_data = d; end
      2: begin if_c.i_rx_strobe = s; if_c.i_rx_data = d; end
      default: ;
    endcase
  endtask

  task automatic send_byte(input int k, input logic [7:0] b);
    drive(k, 1'b1, b);
    tick(2);
    drive(k, 1'b0, b);
    tick(2);
  endtask

  task automatic wait_idle(input int k, input string tag);
    int c = 0;
    while (sending_w[k] && c < 400) begin
      tick(1);
      c++;
    end
    chk(tag, 32'(sending_w[k]), 32'd0);
  endtask

  int s0;

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    tick(3);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_tx_start", 32'(if_a.o_tx_start), 32'd0);
    chk("rst_tx_data", 32'(if_a.o_tx_data), 32'd0);
    chk("rst_flags", 32'({sending_w, overflow_w, dropped_w}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // T1: reverse replay of ABC
    exp_a.push_back("C"); exp_a.push_back("B"); exp_a.push_back("A");
    send_byte(0, "A"); send_byte(0, "B"); send_byte(0, "C");
    chk("t1_count3", 32'(count_a), 32'd3);
    s0 = starts_a;
    send_byte(0, 8'h01);
    chk("t1_sending", 32'(sending_w[0]), 32'd1);
    wait_idle(0, "t1_idle");
    chk("t1_starts", 32'(starts_a - s0), 32'd3);
    chk("t1_count0", 32'(count_a), 32'd0);
    chk("t1_q_empty", 32'(exp_a.size()), 32'd0);

    // T2: forward replay with appended terminator, then a lone terminator
    exp_b.push_back("x"); exp_b.push_back("y"); exp_b.push_back(8'h01);
    send_byte(1, "x"); send_byte(1, "y"); send_byte(1, 8'h01);
    wait_idle(1, "t2_idle");
    chk("t2_q_empty", 32'(exp_b.size()), 32'd0);
    chk("t2_count0", 32'(count_b), 32'd0);
    s0 = starts_b;
    exp_b.push_back(8'h01);
    send_byte(1, 8'h01);
    wait_idle(1, "t2_lone_idle");
    chk("t2_lone_starts", 32'(starts_b - s0), 32'd1);
    chk("t2_lone_q_empty", 32'(exp_b.size()), 32'd0);

    // T3: overflow of a 4-deep buffer
    exp_c.push_back("4"); exp_c.push_back("3"); exp_c.push_back("2"); exp_c.push_back("1");
    send_byte(2, "1"); send_byte(2, "2"); send_byte(2, "3"); send_byte(2, "4");
    chk("t3_full_no_ovf", 32'(overflow_w[2]), 32'd0);
    chk("t3_count4", 32'(count_c), 32'd4);
    send_byte(2, "5");
    chk("t3_ovf_set", 32'(overflow_w[2]), 32'd1);
    send_byte(2, "6");
    chk("t3_count_sat", 32'(count_c), 32'd4);
    send_byte(2, 8'h01);
    wait_idle(2, "t3_idle");
    chk("t3_ovf_clr", 32'(overflow_w[2]), 32'd0);
    chk("t3_count0", 32'(count_c), 32'd0);
    chk("t3_q_empty", 32'(exp_c.size()), 32'd0);

    // T4: lone terminator without append, then a held strobe
    s0 = starts_a;
    send_byte(0, 8'h01);
    tick(10);
    chk("t4_lone_no_start", 32'(starts_a - s0), 32'd0);
    chk("t4_lone_not_sending", 32'(sending_w[0]), 32'd0);
    drive(0, 1'b1, "Q");
    tick(20);
    drive(0, 1'b0, "Q");
    tick(2);
    chk("t4_held_count1", 32'(count_a), 32'd1);
    exp_a.push_back("Q");
    send_byte(0, 8'h01);
    wait_idle(0, "t4_idle");
    chk("t4_q_empty", 32'(exp_a.size()), 32'd0);

    // T5: byte injected during replay is dropped
    exp_a.push_back("c"); exp_a.push_back("b"); exp_a.push_back("a");
    send_byte(0, "a"); send_byte(0, "b"); send_byte(0, "c");
    send_byte(0, 8'h01);
    chk("t5_no_drop_yet", 32'(dropped_w[0]), 32'd0);
    send_byte(0, "Z");
    chk("t5_dropped", 32'(dropped_w[0]), 32'd1);
    wait_idle(0, "t5_idle");
    chk("t5_q_empty", 32'(exp_a.size()), 32'd0);
    chk("t5_count0", 32'(count_a), 32'd0);
    chk("t5_dropped_sticky", 32'(dropped_w[0]), 32'd1);
    send_byte(0, "n");
    chk("t5_next_count1", 32'(count_a), 32'd1);
    exp_a.push_back("n");
    send_byte(0, 8'h01);
    wait_idle(0, "t5_next_idle");
    chk("t5_next_q_empty", 32'(exp_a.size()), 32'd0);

    // T6: asynchronous reset mid-transmission
    exp_a.push_back("r"); exp_a.push_back("q"); exp_a.push_back("p");
    send_byte(0, "p"); send_byte(0, "q"); send_byte(0, "r");
    send_byte(0, 8'h01);
    begin
      int c = 0;
      while (!if_a.i_tx_busy && c < 100) begin
        tick(1);
        c++;
      end
    end
    chk("t6_busy_seen", 32'(if_a.i_tx_busy), 32'd1);
    chk("t6_pending", 32'(exp_a.size()), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count_a), 32'd0);
    chk("t6_rst_sending", 32'(sending_w[0]), 32'd0);
    chk("t6_rst_dropped", 32'(dropped_w[0]), 32'd0);
    chk("t6_rst_tx_data", 32'(if_a.o_tx_data), 32'd0);
    chk("t6_rst_tx_start", 32'(if_a.o_tx_start), 32'd0);
    exp_a.delete();
    s0 = starts_a;
    #2;
    rst_n = 1'b1;
    tick(40);
    chk("t6_no_start", 32'(starts_a - s0), 32'd0);
    exp_a.push_back("k");
    send_byte(0, "k");
    send_byte(0, 8'h01);
    wait_idle(0, "t6_new_idle");
    chk("t6_new_q_empty", 32'(exp_a.size()), 32'd0);
    chk("t6_new_starts", 32'(starts_a - s0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
